// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - sequential restoring divider, one quotient bit per cycle
// Signed division (sgn input) is compiled in only with DIV32_SEQ_SIGNED_EN defined.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, a_q, a_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0]   r_shift, diff;

`ifdef DIV32_SEQ_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic a_neg, b_neg;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif

  // q_q starts as the dividend magnitude and is shifted out into the partial remainder
  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign diff    = r_shift - {1'b0, d_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    a_d     = a_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
`ifdef DIV32_SEQ_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    a_neg   = sgn & a[WIDTH-1];
    b_neg   = sgn & b[WIDTH-1];
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          a_d     = a;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef DIV32_SEQ_SIGNED_EN
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          q_d     = a_neg ? -a : a;
          d_d     = b_neg ? -b : b;
`else
          q_d     = a;
          d_d     = b;
`endif
        end
      end
      S_RUN: begin
        r_d   = diff[WIDTH] ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        dz_d    = (d_q == '0);
        // divide-by-zero reports the raw dividend, not the sign-corrected remainder
        if (d_q == '0) begin
          quo_d = '1;
          rem_d = a_q;
        end else begin
`ifdef DIV32_SEQ_SIGNED_EN
          quo_d = qneg_q ? -q_q : q_q;
          rem_d = rneg_q ? -r_q : r_q;
`else
          quo_d = q_q;
          rem_d = r_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV32_SEQ_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      a_q     <= a_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
`ifdef DIV32_SEQ_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule
